// File: rtl/pipe_ctrl_pkg.sv
// Shared types and reset values for the PIPE rate/power sequencer.
// Holds the power-state encodings, the FSM states and a validity helper.
package pipe_ctrl_pkg;

  typedef enum logic [3:0] {
    PWR_P0  = 4'h0,
    PWR_P0S = 4'h1,
    PWR_P1  = 4'h2,
    PWR_P2  = 4'h3
  } pwr_e;

  typedef enum logic [2:0] {
    ST_RESET_WAIT,
    ST_IDLE,
    ST_PD_WAIT,
    ST_RATE_WAIT,
    ST_ACK_WAIT,
    ST_DONE
  } state_e;

  localparam logic [3:0] CUR_PD_RST   = PWR_P1;
  localparam logic [3:0] CUR_RATE_RST = 4'h0;
  localparam logic [2:0] CUR_PCLK_RST = 3'h0;

  function automatic logic pd_valid(input logic [3:0] pd);
    return pd <= PWR_P2;
  endfunction

endpackage

// File: rtl/pipe_lat_counter.sv
// Latency counter for the sequencer wait states.
// Saturates at the terminal count; done is high on the last wait cycle.
module pipe_lat_counter #(
  parameter int W = 6
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic [W-1:0] term_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign done_o = (cnt_q == term_i - W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (!done_o)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pipe_rate_power_ctrl.sv
// PIPE command/status sequencer: applies PowerDown and Rate/PCLKRate
// changes after fixed latencies and reports completion on PhyStatus.
module pipe_rate_power_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int pipe_num_of_lanes = 4,
  parameter int RESET_DONE_CYCLES = 16,
  parameter int PD_LATENCY        = 8,
  parameter int RATE_LATENCY      = 32
) (
  input  logic                           PCLK,
  input  logic                           Reset,
  input  logic [4*pipe_num_of_lanes-1:0] PowerDown,
  input  logic [3:0]                     Rate,
  input  logic [2:0]                     PCLKRate,
  input  logic                           PclkChangeAck,
  output logic [pipe_num_of_lanes-1:0]   PhyStatus,
  output logic                           PclkChangeOk,
  output logic [3:0]                     CurPowerDown,
  output logic [3:0]                     CurRate,
  output logic [2:0]                     CurPCLKRate,
  output logic                           Busy,
  output logic                           ProtocolError
);

  localparam int MAX_A = (RESET_DONE_CYCLES > PD_LATENCY) ?
                         RESET_DONE_CYCLES : PD_LATENCY;
  localparam int MAX_LAT = (MAX_A > RATE_LATENCY) ? MAX_A : RATE_LATENCY;
  localparam int CW = $clog2(MAX_LAT + 1);
  localparam logic [pipe_num_of_lanes-1:0] PHY_ALL = '1;

  state_e                       state_q;
  logic [pipe_num_of_lanes-1:0] phy_q;
  logic                         ok_q, busy_q, err_q;
  logic [3:0]                   cur_pd_q, cur_rate_q;
  logic [3:0]                   lat_pd_q, lat_rate_q;
  logic [2:0]                   cur_pclk_q, lat_pclk_q;

  logic [3:0]    pd0;
  logic          lane_mis, pd_ok, pd_req, rate_req;
  logic          stray_ack, lat_clr, lat_done;
  logic [CW-1:0] lat_term;

  assign pd0 = PowerDown[3:0];

  always_comb begin
    lane_mis = 1'b0;
    for (int i = 1; i < pipe_num_of_lanes; i++)
      if (PowerDown[4*i +: 4] != pd0) lane_mis = 1'b1;
  end

  assign pd_ok     = pd_valid(pd0);
  assign pd_req    = pd_ok && (pd0 != cur_pd_q);
  // A rate change while out of P0 stays pending until P0 is reached.
  assign rate_req  = pd_ok && (pd0 == cur_pd_q) &&
                     (Rate != cur_rate_q) && (cur_pd_q == PWR_P0);
  assign stray_ack = PclkChangeAck && (state_q != ST_ACK_WAIT);

  always_comb begin
    lat_term = CW'(RATE_LATENCY);
    unique case (state_q)
      ST_RESET_WAIT: lat_term = CW'(RESET_DONE_CYCLES);
      ST_PD_WAIT:    lat_term = CW'(PD_LATENCY);
      default:       ;
    endcase
  end

  assign lat_clr = lat_done ||
    !(state_q inside {ST_RESET_WAIT, ST_PD_WAIT, ST_RATE_WAIT});

  pipe_lat_counter #(.W(CW)) u_lat (
    .clk_i  (PCLK),
    .rst_i  (Reset),
    .clr_i  (lat_clr),
    .term_i (lat_term),
    .done_o (lat_done)
  );

  always_ff @(posedge PCLK or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_RESET_WAIT;
      phy_q      <= PHY_ALL;
      ok_q       <= 1'b0;
      busy_q     <= 1'b1;
      err_q      <= 1'b0;
      cur_pd_q   <= CUR_PD_RST;
      cur_rate_q <= CUR_RATE_RST;
      cur_pclk_q <= CUR_PCLK_RST;
      lat_pd_q   <= CUR_PD_RST;
      lat_rate_q <= CUR_RATE_RST;
      lat_pclk_q <= CUR_PCLK_RST;
    end else begin
      err_q <= stray_ack ||
               ((state_q == ST_IDLE) && (lane_mis || !pd_ok));
      unique case (state_q)
        ST_RESET_WAIT: begin
          if (lat_done) begin
            phy_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          unique case (1'b1)
            pd_req: begin
              lat_pd_q <= pd0;
              busy_q   <= 1'b1;
              state_q  <= ST_PD_WAIT;
            end
            rate_req: begin
              lat_rate_q <= Rate;
              lat_pclk_q <= PCLKRate;
              busy_q     <= 1'b1;
              state_q    <= ST_RATE_WAIT;
            end
            default: ;
          endcase
        end
        ST_PD_WAIT: begin
          if (lat_done) begin
            cur_pd_q <= lat_pd_q;
            phy_q    <= PHY_ALL;
            state_q  <= ST_DONE;
          end
        end
        ST_RATE_WAIT: begin
          if (lat_done) begin
            ok_q    <= 1'b1;
            state_q <= ST_ACK_WAIT;
          end
        end
        ST_ACK_WAIT: begin
          if (PclkChangeAck) begin
            ok_q       <= 1'b0;
            cur_rate_q <= lat_rate_q;
            cur_pclk_q <= lat_pclk_q;
            phy_q      <= PHY_ALL;
            state_q    <= ST_DONE;
          end
        end
        ST_DONE: begin
          phy_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign PhyStatus     = phy_q;
  assign PclkChangeOk  = ok_q;
  assign CurPowerDown  = cur_pd_q;
  assign CurRate       = cur_rate_q;
  assign CurPCLKRate   = cur_pclk_q;
  assign Busy          = busy_q;
  assign ProtocolError = err_q;

endmodule

// File: tb/tb_pipe_rate_power_ctrl.sv
// Bench for pipe_rate_power_ctrl: timestamp-based reference model,
// directed sequences with literal timing pins, then random traffic.
module tb_pipe_rate_power_ctrl;

  localparam int RST_CYC  = 16;
  localparam int PD_LAT   = 8;
  localparam int RATE_LAT = 32;

  logic        PCLK = 1'b0;
  logic        Reset;
  logic [15:0] PowerDown;
  logic [3:0]  Rate;
  logic [2:0]  PCLKRate;
  logic        PclkChangeAck;
  logic [3:0]  PhyStatus;
  logic        PclkChangeOk;
  logic [3:0]  CurPowerDown;
  logic [3:0]  CurRate;
  logic [2:0]  CurPCLKRate;
  logic        Busy;
  logic        ProtocolError;

  pipe_rate_power_ctrl dut (
    .PCLK          (PCLK),
    .Reset         (Reset),
    .PowerDown     (PowerDown),
    .Rate          (Rate),
    .PCLKRate      (PCLKRate),
    .PclkChangeAck (PclkChangeAck),
    .PhyStatus     (PhyStatus),
    .PclkChangeOk  (PclkChangeOk),
    .CurPowerDown  (CurPowerDown),
    .CurRate       (CurRate),
    .CurPCLKRate   (CurPCLKRate),
    .Busy          (Busy),
    .ProtocolError (ProtocolError)
  );

  always #5 PCLK = ~PCLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: applied values plus the timestamp of the operation in flight.
  int         cyc, free_at, op, t_acc, t_ack;
  bit         acked;
  logic [3:0] l_pd, l_rate, e_pd, e_rate;
  logic [2:0] l_pclk, e_pclk;
  bit         e_phy, e_ok, e_busy, e_err;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    e_pd = 4'h2; e_rate = 4'h0; e_pclk = 3'h0;
    e_phy = 1; e_ok = 0; e_busy = 1; e_err = 0;
    op = 0; acked = 0; free_at = RST_CYC; cyc = 0;
  endtask

  task automatic model_step();
    int n, m;
    logic [3:0] pd0;
    bit mism, idle, in_ack;
    n = cyc;
    m = cyc + 1;
    pd0 = PowerDown[3:0];
    mism = 0;
    for (int i = 1; i < 4; i++)
      if (PowerDown[4*i +: 4] != pd0) mism = 1;
    idle   = (op == 0) && (n >= free_at);
    in_ack = (op == 2) && !acked && (n >= t_acc + RATE_LAT + 1);
    e_err  = (PclkChangeAck && !in_ack) || (idle && (mism || pd0 > 3));
    if (idle && pd0 <= 3) begin
      if (pd0 != e_pd) begin
        op = 1; t_acc = n; l_pd = pd0;
      end else if (Rate != e_rate && e_pd == 0) begin
        op = 2; t_acc = n; acked = 0;
        l_rate = Rate; l_pclk = PCLKRate;
      end
    end
    if (in_ack && PclkChangeAck) begin
      acked = 1; t_ack = n;
    end
    e_phy = (m < RST_CYC);
    if (op == 1 && m == t_acc + PD_LAT + 1) begin
      e_phy = 1; e_pd = l_pd; op = 0; free_at = m + 1;
    end
    if (op == 2 && acked && m == t_ack + 1) begin
      e_phy = 1; e_rate = l_rate; e_pclk = l_pclk;
      op = 0; acked = 0; free_at = m + 1;
    end
    e_ok   = (op == 2) && !acked && (m >= t_acc + RATE_LAT + 1);
    e_busy = !((op == 0) && (m >= free_at));
    cyc = m;
  endtask

  task automatic compare();
    chk("phystatus", 32'(PhyStatus), 32'(e_phy ? 4'hF : 4'h0));
    chk("pclkok", 32'(PclkChangeOk), 32'(e_ok));
    chk("curpd", 32'(CurPowerDown), 32'(e_pd));
    chk("currate", 32'(CurRate), 32'(e_rate));
    chk("curpclk", 32'(CurPCLKRate), 32'(e_pclk));
    chk("busy", 32'(Busy), 32'(e_busy));
    chk("perr", 32'(ProtocolError), 32'(e_err));
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
    model_step();
    compare();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #1;
    model_reset();
    compare();
    repeat (2) @(posedge PCLK);
    #1;
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic wait_for(input int sel, input int limit, output int k);
    bit hit;
    k = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      case (sel)
        0:       hit = (PhyStatus == 4'h0);
        1:       hit = (PhyStatus == 4'hF);
        2:       hit = PclkChangeOk;
        default: hit = !PclkChangeOk;
      endcase
      if (hit) begin
        k = i;
        break;
      end
    end
  endtask

  initial begin
    int k, pulses, r;
    logic [3:0] v;
    Reset = 1'b1;
    PowerDown = 16'h2222;
    Rate = 4'h0;
    PCLKRate = 3'h0;
    PclkChangeAck = 1'b0;
    #1;
    model_reset();
    compare();
    repeat (2) @(posedge PCLK);
    #1;
    Reset = 1'b0;
    model_reset();

    wait_for(0, 40, k);
    chk("rst_release_cyc", 32'(k), 32'd16);
    chk("rst_curpd", 32'(CurPowerDown), 32'h2);
    chk("rst_busy", 32'(Busy), 32'h0);

    PowerDown = 16'h0000;
    wait_for(1, 20, k);
    chk("pd_pulse_cyc", 32'(k), 32'd9);
    chk("pd_applied", 32'(CurPowerDown), 32'h0);
    tick();

    Rate = 4'h1;
    PCLKRate = 3'h1;
    wait_for(2, 40, k);
    chk("ok_rise_cyc", 32'(k), 32'd33);
    repeat (5) tick();
    PclkChangeAck = 1'b1;
    tick();
    PclkChangeAck = 1'b0;
    chk("ok_fall", 32'(PclkChangeOk), 32'h0);
    chk("rate_applied", 32'(CurRate), 32'h1);
    chk("pclk_applied", 32'(CurPCLKRate), 32'h1);
    chk("rate_pulse", 32'(PhyStatus), 32'hF);
    tick();

    PowerDown = 16'h2222;
    wait_for(1, 20, k);
    tick();
    PowerDown = 16'h0000;
    Rate = 4'h2;
    pulses = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (PhyStatus == 4'hF) pulses++;
      PclkChangeAck = PclkChangeOk;
    end
    PclkChangeAck = 1'b0;
    chk("both_pulses", 32'(pulses), 32'd2);
    chk("both_rate", 32'(CurRate), 32'h2);
    chk("both_pd", 32'(CurPowerDown), 32'h0);

    PowerDown = 16'h2222;
    wait_for(1, 20, k);
    tick();
    PowerDown = 16'h0200;
    tick();
    chk("mismatch_err", 32'(ProtocolError), 32'h1);
    wait_for(1, 20, k);
    PowerDown = 16'h0000;
    chk("mismatch_pd", 32'(CurPowerDown), 32'h0);
    tick();

    PowerDown = 16'h7777;
    tick();
    chk("invalid_err", 32'(ProtocolError), 32'h1);
    chk("invalid_busy", 32'(Busy), 32'h0);
    tick();
    chk("invalid_pd", 32'(CurPowerDown), 32'h0);
    PowerDown = 16'h0000;
    tick();

    PclkChangeAck = 1'b1;
    tick();
    PclkChangeAck = 1'b0;
    chk("stray_ack_err", 32'(ProtocolError), 32'h1);
    tick();

    Rate = 4'h3;
    wait_for(2, 40, k);
    chk("ok_rise2", 32'(k), 32'd33);
    Reset = 1'b1;
    #1;
    chk("abort_ok", 32'(PclkChangeOk), 32'h0);
    chk("abort_rate", 32'(CurRate), 32'h0);
    model_reset();
    compare();
    repeat (2) @(posedge PCLK);
    #1;
    Reset = 1'b0;
    model_reset();
    wait_for(0, 40, k);
    chk("rst_release2", 32'(k), 32'd16);

    for (int i = 0; i < 2500; i++) begin
      tick();
      if ($urandom_range(0, 39) == 0) begin
        r = int'($urandom_range(0, 99));
        if (r < 70) begin
          v = 4'($urandom_range(0, 3));
          PowerDown = {4{v}};
        end else if (r < 85) begin
          v = 4'($urandom_range(4, 15));
          PowerDown = {4{v}};
        end else begin
          PowerDown = 16'($urandom);
        end
      end
      if ($urandom_range(0, 49) == 0) begin
        Rate = 4'($urandom_range(0, 3));
        PCLKRate = 3'($urandom_range(0, 7));
      end
      PclkChangeAck = (e_ok && $urandom_range(0, 3) == 0) ||
                      ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 799) == 0) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
